// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 channel multiplexer with fixed-select or round-robin grant,
// a single-entry valid/ready output register and a count of accepted input words.
module mux_nto1_reg #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         xfer_cnt
);

  localparam int               NPAD    = 2 ** SEL_W;
  localparam logic [SEL_W:0]   CH_L    = (SEL_W + 1)'(CH);
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CH - 1);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;
  logic [15:0]      r_xfer_cnt;
  logic [SEL_W-1:0] r_ptr;

  logic [NPAD-1:0]  w_vld_pad;
  logic [NPAD-1:0]  w_rdy_pad;
  logic [WIDTH-1:0] w_ch_data [NPAD];
  logic [SEL_W-1:0] w_gnt;
  logic             w_gnt_vld;
  logic             w_sel_ok;
  logic             w_slot_free;
  logic             w_xfer;

  // Returns {found, index}. Scanning from the farthest candidate back toward ptr+1
  // lets the nearest valid channel overwrite earlier hits, giving first-match order.
  function automatic logic [SEL_W:0] rr_pick(input logic [NPAD-1:0] vld,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0] res;
    logic [SEL_W:0] idx;
    res = '0;
    for (int k = CH; k >= 1; k--) begin
      idx = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (idx >= CH_L) idx = idx - CH_L;
      if (vld[idx[SEL_W-1:0]]) res = {1'b1, idx[SEL_W-1:0]};
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
    if (gi < CH) begin : g_real
      assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end else begin : g_zero
      assign w_ch_data[gi] = '0;
    end
  end

  assign w_vld_pad   = NPAD'(in_valid);
  assign w_sel_ok    = ({1'b0, sel} < CH_L);
  assign w_slot_free = !r_out_valid || out_ready;

  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    if (mode) begin
      {w_gnt_vld, w_gnt} = rr_pick(w_vld_pad, r_ptr);
    end else begin
      w_gnt_vld = w_sel_ok;
      w_gnt     = sel;
    end
  end

  // Grant stage: only the granted channel may see ready, and never during reset.
  assign w_rdy_pad = (w_gnt_vld && w_slot_free && !rst) ? (NPAD'(1) << w_gnt) : '0;
  assign in_ready  = w_rdy_pad[CH-1:0];
  assign w_xfer    = |(w_rdy_pad & w_vld_pad);

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_xfer_cnt  <= '0;
      r_ptr       <= PTR_RST;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_gnt];
      r_out_ch    <= w_gnt;
      r_xfer_cnt  <= r_xfer_cnt + 16'd1;
      if (mode) r_ptr <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Self-checking bench for mux_nto1_reg: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the grant and output slot.
module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_ready;
  logic        d3_mode;
  logic [1:0]  d3_sel;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_ch;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic [15:0] d3_xfer_cnt;

  int n_total = 0;
  int n_bad   = 0;

  bit          m_valid;
  logic [7:0]  m_data;
  int          m_ch;
  int          m_cnt;
  int          m_ptr;

  always #5 clk = ~clk;

  mux_nto1_reg #(.WIDTH(8), .CH(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  mux_nto1_reg #(.WIDTH(8), .CH(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data), .out_ch(d3_out_ch),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .xfer_cnt(d3_xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (!mode) return (int'(sel) < 4) ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic pre();
    int g;
    logic [3:0] e;
    #1;
    g = model_grant();
    e = '0;
    if (!rst && g >= 0 && (!m_valid || out_ready)) e[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(e));
  endtask

  task automatic edge_post();
    int g;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 8'h00; m_ch = 0; m_cnt = 0; m_ptr = 3;
    end else if (g >= 0 && in_valid[g] && (!m_valid || out_ready)) begin
      m_valid = 1;
      m_data  = in_data[g*8 +: 8];
      m_ch    = g;
      m_cnt   = (m_cnt + 1) % 65536;
      if (mode) m_ptr = g;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_ch",    32'(out_ch),    32'(m_ch));
    check("out_data",  32'(out_data),  32'(m_data));
    check("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
  endtask

  task automatic step();
    pre();
    edge_post();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    d3_in_data = '0; d3_in_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_out_ready = 1'b1;
    m_valid = 0; m_data = 8'h00; m_ch = 0; m_cnt = 0; m_ptr = 3;

    // reset state
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);

    // fixed select of channel 2
    in_data = 32'h4332_2110; in_valid = 4'b1111; mode = 1'b0; sel = 2'd2;
    #1 check("fix_ready", 32'(in_ready), 32'h4);
    edge_post();
    check("fix_data", 32'(out_data), 32'h32);
    check("fix_ch", 32'(out_ch), 32'd2);

    // round-robin sequence over channels 0,1,3
    do_reset();
    mode = 1'b1; in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_seq", 32'(out_ch), 32'(exp_seq[i]));
    end
    check("rr_cnt", 32'(xfer_cnt), 32'd6);

    // backpressure for three cycles after a transfer
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; in_data = 32'hDDCC_BBAA;
    step();
    out_ready = 1'b0; in_data = 32'h4433_2211;
    repeat (3) begin
      step();
      check("bp_hold", 32'(out_data), 32'hBB);
    end
    check("bp_cnt", 32'(xfer_cnt), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_release", 32'(out_data), 32'h22);
    check("bp_cnt2", 32'(xfer_cnt), 32'd2);

    // reset while a word is held, then round-robin restart from channel 0
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    rst = 1'b0; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    step();
    check("mid_rst_first", 32'(out_ch), 32'd0);

    // three-channel instance: out-of-range select grants nothing
    do_reset();
    in_valid = 4'b0000;
    d3_in_data = 24'h77_66_55; d3_in_valid = 3'b111; d3_mode = 1'b0; d3_sel = 2'd3;
    repeat (3) begin
      pre();
      check("ch3_ready", 32'(d3_in_ready), 32'd0);
      edge_post();
      check("ch3_valid", 32'(d3_out_valid), 32'd0);
      check("ch3_cnt", 32'(d3_xfer_cnt), 32'd0);
    end
    d3_sel = 2'd1;
    pre();
    check("ch3_ready1", 32'(d3_in_ready), 32'h2);
    edge_post();
    check("ch3_data1", 32'(d3_out_data), 32'h66);
    check("ch3_cnt1", 32'(d3_xfer_cnt), 32'd1);
    d3_in_valid = '0;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 64) == 0;
      step();
    end
    rst = 1'b0;

    // counter wrap through a long run at full throughput
    do_reset();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; in_data = 32'h0000_00A5;
    for (int i = 0; i < 70000 && m_cnt != 65535; i++) step();
    check("wrap_ffff", 32'(xfer_cnt), 32'h0000_FFFF);
    step();
    check("wrap_zero", 32'(xfer_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
